// File: rtl/tile_writer.sv
// Character tile RAM write side: consumes a byte stream, keeps a text cursor,
// and writes printable bytes at address {row, col}. Control codes CR/LF/BS/FF
// move the cursor; FF and reset sweep the whole RAM with spaces.
//
// state  | meaning
// CLEAR  | writing 0x20 to every address, one per cycle; input stalled
// IDLE   | accepting bytes, one write per printable byte

module tile_writer #(
  parameter int ZOOM = 0,
  parameter int COLS = 80 >> ZOOM,
  parameter int ROWS = 60 >> ZOOM,
  localparam int AW  = 13 - 2 * ZOOM,
  localparam int CW  = 7 - ZOOM,
  localparam int RW  = 6 - ZOOM
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    char_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [AW-1:0] waddr,
  output logic [7:0]    wdata,
  output logic          write_en,
  output logic [CW-1:0] cur_col,
  output logic [RW-1:0] cur_row,
  output logic          busy_o
);

  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [7:0]    CH_CR   = 8'h0D;
  localparam logic [7:0]    CH_LF   = 8'h0A;
  localparam logic [7:0]    CH_BS   = 8'h08;
  localparam logic [7:0]    CH_FF   = 8'h0C;
  localparam logic [7:0]    CH_SP   = 8'h20;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_addr, clr_addr_nxt;
  logic [AW-1:0]   waddr_nxt;
  logic [7:0]      wdata_nxt;
  logic            we_nxt, ready_nxt, busy_nxt;
  logic [CW-1:0]   col_nxt, col_dec;
  logic [RW-1:0]   row_nxt, row_inc;
  logic            xfer, clr_last;

  // ready_o is registered and only high in IDLE, so a transfer implies IDLE
  assign xfer     = valid_i & ready_o;
  assign clr_last = (clr_addr == {AW{1'b1}});
  assign col_dec  = cur_col - 1'b1;
  assign row_inc  = (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  // Next-state decode: clear sweep ends on the last address, FF restarts it
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_last) state_nxt = S_IDLE;
      S_IDLE:  if (xfer && char_i == CH_FF) state_nxt = S_CLEAR;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Next values of all registered outputs, cursor and clear pointer
  always_comb begin
    clr_addr_nxt = clr_addr;
    col_nxt      = cur_col;
    row_nxt      = cur_row;
    we_nxt       = 1'b0;
    waddr_nxt    = waddr;
    wdata_nxt    = wdata;
    ready_nxt    = ready_o;
    busy_nxt     = busy_o;
    case (state)
      S_CLEAR: begin
        we_nxt       = 1'b1;
        waddr_nxt    = clr_addr;
        wdata_nxt    = CH_SP;
        clr_addr_nxt = clr_addr + 1'b1;
        col_nxt      = '0;
        row_nxt      = '0;
        ready_nxt    = clr_last;
        busy_nxt     = ~clr_last;
      end
      S_IDLE: begin
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
        if (xfer) begin
          case (char_i)
            CH_CR: col_nxt = '0;
            CH_LF: begin
              col_nxt = '0;
              row_nxt = row_inc;
            end
            CH_BS: begin
              if (cur_col != '0) begin
                col_nxt   = col_dec;
                we_nxt    = 1'b1;
                waddr_nxt = {cur_row, col_dec};
                wdata_nxt = CH_SP;
              end
            end
            CH_FF: begin
              clr_addr_nxt = '0;
              col_nxt      = '0;
              row_nxt      = '0;
              ready_nxt    = 1'b0;
              busy_nxt     = 1'b1;
            end
            default: begin
              we_nxt    = 1'b1;
              waddr_nxt = {cur_row, cur_col};
              wdata_nxt = char_i;
              if (cur_col == COL_MAX) begin
                col_nxt = '0;
                row_nxt = row_inc;
              end else begin
                col_nxt = cur_col + 1'b1;
              end
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr <= '0;
      cur_col  <= '0;
      cur_row  <= '0;
      write_en <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b1;
    end else begin
      clr_addr <= clr_addr_nxt;
      cur_col  <= col_nxt;
      cur_row  <= row_nxt;
      write_en <= we_nxt;
      waddr    <= waddr_nxt;
      wdata    <= wdata_nxt;
      ready_o  <= ready_nxt;
      busy_o   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_tile_writer.sv
// Directed bench for tile_writer at ZOOM=0 (80x60 tiles, 13-bit address).
// Inputs change on the falling edge, outputs are sampled on the falling edge.

module tb_tile_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  char_i;
  logic        valid_i;
  logic        ready_o;
  logic [12:0] waddr;
  logic [7:0]  wdata;
  logic        write_en;
  logic [6:0]  cur_col;
  logic [5:0]  cur_row;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tile_writer dut (
    .clk      (clk),
    .rst      (rst),
    .char_i   (char_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .waddr    (waddr),
    .wdata    (wdata),
    .write_en (write_en),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy_o   (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle transfer; called at a falling edge, returns at the next one
  task automatic send(input logic [7:0] b);
    char_i  = b;
    valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic chk_cursor(input string tag, input int col, input int row);
    chk({tag, "_col"}, 32'(cur_col), 32'(col));
    chk({tag, "_row"}, 32'(cur_row), 32'(row));
  endtask

  // Follows one full clear sweep: addresses 0..8191 in order, all 0x20,
  // ready_o rising only once all 8192 strobes have been seen.
  task automatic check_clear(input string tag);
    int n   = 0;
    int bad = 0;
    bit done = 1'b0;
    for (int i = 0; i < 9000 && !done; i++) begin
      @(negedge clk);
      if (write_en) begin
        if (waddr !== n[12:0] || wdata !== 8'h20) bad++;
        n++;
      end
      if (ready_o) done = 1'b1;
    end
    chk({tag, "_done"},  32'(done), 32'd1);
    chk({tag, "_count"}, 32'(n), 32'd8192);
    chk({tag, "_seq"},   32'(bad), 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk_cursor(tag, 0, 0);
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    char_i  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we",    32'(write_en), 32'd0);
    chk("rst_ready", 32'(ready_o),  32'd0);
    chk("rst_busy",  32'(busy_o),   32'd1);
    chk("rst_waddr", 32'(waddr),    32'd0);
    chk("rst_wdata", 32'(wdata),    32'd0);
    chk_cursor("rst", 0, 0);
    rst = 1'b0;
    // valid_i held high during the clear must be ignored
    valid_i = 1'b1;
    char_i  = 8'h41;
    check_clear("clr0");
    valid_i = 1'b0;

    // back-to-back 'A','B'
    char_i  = 8'h41;
    valid_i = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("a_we",    32'(write_en), 32'd1);
    chk("a_waddr", 32'(waddr),    32'd0);
    chk("a_wdata", 32'(wdata),    32'h41);
    char_i = 8'h42;
    @(posedge clk); @(negedge clk);
    valid_i = 1'b0;
    chk("b_we",    32'(write_en), 32'd1);
    chk("b_waddr", 32'(waddr),    32'd1);
    chk("b_wdata", 32'(wdata),    32'h42);
    chk_cursor("ab", 2, 0);
    @(posedge clk); @(negedge clk);
    chk("ab_idle_we", 32'(write_en), 32'd0);
    chk_cursor("ab_hold", 2, 0);

    // full row of 80 printables, wrap to row 1
    send(8'h0D);
    chk("cr0_we", 32'(write_en), 32'd0);
    chk_cursor("cr0", 0, 0);
    for (int i = 0; i < 80; i++) send(8'h61 + 8'(i % 26));
    chk("row_last_waddr", 32'(waddr), 32'd79);
    chk("row_last_wdata", 32'(wdata), 32'h61 + 32'(79 % 26));
    chk_cursor("row_wrap", 0, 1);
    send(8'h5A);
    chk("row1_waddr", 32'(waddr), 32'd128);
    chk("row1_wdata", 32'(wdata), 32'h5A);
    chk_cursor("row1", 1, 1);

    // CR / LF / BS
    send(8'h0D);
    chk("cr1_we", 32'(write_en), 32'd0);
    chk_cursor("cr1", 0, 1);
    send(8'h0A);
    send(8'h0A);
    repeat (5) send(8'h78);
    chk_cursor("pos53", 5, 3);
    send(8'h0D);
    chk("cr2_we", 32'(write_en), 32'd0);
    chk_cursor("cr2", 0, 3);
    repeat (5) send(8'h78);
    send(8'h08);
    chk("bs_we",    32'(write_en), 32'd1);
    chk("bs_waddr", 32'(waddr),    32'd388);
    chk("bs_wdata", 32'(wdata),    32'h20);
    chk_cursor("bs", 4, 3);

    // bottom-right corner wrap via printables
    repeat (56) send(8'h0A);
    chk_cursor("row59", 0, 59);
    for (int i = 0; i < 80; i++) send(8'h77);
    chk("corner_waddr", 32'(waddr), 32'd7631);
    chk("corner_wdata", 32'(wdata), 32'h77);
    chk_cursor("corner", 0, 0);

    // LF at the bottom row wraps, BS at col 0 does nothing
    repeat (59) send(8'h0A);
    chk_cursor("lf59", 0, 59);
    send(8'h0A);
    chk("lfwrap_we", 32'(write_en), 32'd0);
    chk_cursor("lfwrap", 0, 0);
    send(8'h08);
    chk("bs0_we", 32'(write_en), 32'd0);
    chk_cursor("bs0", 0, 0);

    // FF from (10,10): full clear
    repeat (10) send(8'h0A);
    repeat (10) send(8'h71);
    chk_cursor("pos1010", 10, 10);
    send(8'h0C);
    chk("ff_ready", 32'(ready_o),  32'd0);
    chk("ff_busy",  32'(busy_o),   32'd1);
    chk("ff_we",    32'(write_en), 32'd0);
    chk_cursor("ff", 0, 0);
    check_clear("clr1");
    send(8'h4D);
    chk("post_ff_waddr", 32'(waddr), 32'd0);
    chk("post_ff_wdata", 32'(wdata), 32'h4D);

    // FF then reset in the middle of the sweep
    send(8'h0C);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
        if (write_en && waddr == 13'd100) hit = 1'b1;
        else @(negedge clk);
      end
      chk("mid_hit100", 32'(hit), 32'd1);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_we",    32'(write_en), 32'd0);
    chk("mid_rst_ready", 32'(ready_o),  32'd0);
    chk("mid_rst_busy",  32'(busy_o),   32'd1);
    rst = 1'b0;
    check_clear("clr2");
    send(8'h4E);
    chk("post_rst_waddr", 32'(waddr), 32'd0);
    chk("post_rst_wdata", 32'(wdata), 32'h4E);
    chk_cursor("post_rst", 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
